// File: rtl/mac_vector_if.sv
// mac_vector_if: streaming handshake bundle for the mac_vector unit.
//   Input side : in_valid/in_ready handshake carrying x, w, in_last, bias, relu_en.
//   Output side: out_valid/out_ready handshake carrying out_data, out_sat.
// Modports:
//   master - the producer/consumer around the unit (drives beats, accepts results)
//   slave  - the mac_vector unit itself
interface mac_vector_if #(
  parameter int X_WIDTH   = 4,
  parameter int W_WIDTH   = 4,
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [X_WIDTH-1:0]   x;
  logic [W_WIDTH-1:0]   w;
  logic                 in_last;
  logic [OUT_WIDTH-1:0] bias;
  logic                 relu_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, x, w, in_last, bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, x, w, in_last, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_vector.sv
// mac_vector: streaming multiply-accumulate with bias, optional ReLU and
// output saturation. One result per vector of (x, w) beats.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   clear  - synchronous abort: drops partial vector and pending result
//   bus    - mac_vector_if.slave: input beat handshake and result handshake
// Pipeline: beat accepted at edge E -> product reg at E, accumulate at E+1,
// result (ReLU + clip) registered at E+2 for the last beat of a vector.
module mac_vector #(
  parameter int X_WIDTH   = 4,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clear,
  mac_vector_if.slave bus
);
  localparam int   PW   = X_WIDTH + W_WIDTH;
  // Two guard bits so sums and comparisons against limits never overflow.
  localparam int   EW   = ACC_WIDTH + 2;
  localparam logic IS_S = (SIGNED != 0);

  localparam logic signed [EW-1:0] ONE     = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] ACC_MAX = IS_S ? (ONE <<< (ACC_WIDTH-1)) - ONE
                                                  : (ONE <<< ACC_WIDTH) - ONE;
  localparam logic signed [EW-1:0] ACC_MIN = IS_S ? -(ONE <<< (ACC_WIDTH-1)) : '0;
  localparam logic signed [EW-1:0] OUT_MAX = IS_S ? (ONE <<< (OUT_WIDTH-1)) - ONE
                                                  : (ONE <<< OUT_WIDTH) - ONE;
  localparam logic signed [EW-1:0] OUT_MIN = IS_S ? -(ONE <<< (OUT_WIDTH-1)) : '0;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t               state_q, state_d;
  logic                 run_q, run_d;
  logic [PW-1:0]        p_q, p_d;
  logic                 p_vld_q, p_vld_d;
  logic                 p_first_q, p_first_d;
  logic                 p_last_q, p_last_d;
  logic [OUT_WIDTH-1:0] bias_q, bias_d;
  logic                 relu_q, relu_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic                 a_last_q, a_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic                 in_ready;
  logic                 beat;
  logic signed [PW-1:0] x_m, w_m, prod;
  logic signed [EW-1:0] p_ext, bias_ext, acc_ext, base, sum, acc_clip;
  logic signed [EW-1:0] relu_val, out_clip;
  logic                 acc_hi, acc_lo, out_hi, out_lo;
  logic                 unused_bits;

  // run_q keeps in_ready low while in reset and until the first clock edge.
  assign in_ready = run_q && (state_q == IDLE || state_q == ACCUM);
  assign beat     = bus.in_valid && in_ready && !clear;

  // Operands extended to the full product width; the low PW bits of the
  // product are exact for both signed and unsigned interpretations.
  assign x_m  = {{(PW-X_WIDTH){IS_S & bus.x[X_WIDTH-1]}}, bus.x};
  assign w_m  = {{(PW-W_WIDTH){IS_S & bus.w[W_WIDTH-1]}}, bus.w};
  assign prod = x_m * w_m;

  assign p_ext    = {{(EW-PW){IS_S & p_q[PW-1]}}, p_q};
  assign bias_ext = {{(EW-OUT_WIDTH){IS_S & bias_q[OUT_WIDTH-1]}}, bias_q};
  assign acc_ext  = {{(EW-ACC_WIDTH){IS_S & acc_q[ACC_WIDTH-1]}}, acc_q};

  // Accumulate stage: the first beat of a vector starts from the bias.
  assign base     = p_first_q ? bias_ext : acc_ext;
  assign sum      = base + p_ext;
  assign acc_hi   = sum > ACC_MAX;
  assign acc_lo   = sum < ACC_MIN;
  assign acc_clip = acc_hi ? ACC_MAX : (acc_lo ? ACC_MIN : sum);

  // Output stage: ReLU then clip to the output range.
  assign relu_val = (relu_q && acc_ext[EW-1]) ? '0 : acc_ext;
  assign out_hi   = relu_val > OUT_MAX;
  assign out_lo   = relu_val < OUT_MIN;
  assign out_clip = out_hi ? OUT_MAX : (out_lo ? OUT_MIN : relu_val);

  // Guard bits are always zero/sign copies after clipping.
  assign unused_bits = ^{acc_clip[EW-1:ACC_WIDTH], out_clip[EW-1:OUT_WIDTH]};

  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    p_d         = p_q;
    p_vld_d     = 1'b0;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    a_last_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (beat) begin
      p_d       = prod;
      p_vld_d   = 1'b1;
      p_first_d = (state_q == IDLE);
      p_last_d  = bus.in_last;
      if (state_q == IDLE) begin
        bias_d = bus.bias;
        relu_d = bus.relu_en;
      end
    end

    if (p_vld_q) begin
      acc_d    = acc_clip[ACC_WIDTH-1:0];
      // Sticky flag restarts with each vector's first accumulation.
      sat_d    = (sat_q & ~p_first_q) | acc_hi | acc_lo;
      a_last_d = p_last_q;
    end

    if (a_last_q) begin
      out_valid_d = 1'b1;
      out_data_d  = out_clip[OUT_WIDTH-1:0];
      out_sat_d   = sat_q | out_hi | out_lo;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE:    if (beat) state_d = bus.in_last ? DRAIN : ACCUM;
      ACCUM:   if (beat && bus.in_last) state_d = DRAIN;
      DRAIN:   if (a_last_q) state_d = HOLD;
      HOLD:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over any beat or result transfer in the same cycle.
    if (clear) begin
      state_d     = IDLE;
      p_vld_d     = 1'b0;
      a_last_d    = 1'b0;
      acc_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      a_last_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      p_q         <= p_d;
      p_vld_q     <= p_vld_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      a_last_q    <= a_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_mac_vector.sv
module tb_mac_vector;
  localparam int MAXN = 600;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  always #5 clk = ~clk;

  mac_vector_if #(.X_WIDTH(4), .W_WIDTH(4), .OUT_WIDTH(8)) ifu ();
  mac_vector_if #(.X_WIDTH(4), .W_WIDTH(4), .OUT_WIDTH(8)) ifs ();

  mac_vector #(.X_WIDTH(4), .W_WIDTH(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifu.slave)
  );
  mac_vector #(.X_WIDTH(4), .W_WIDTH(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifs.slave)
  );

  int tests = 0;
  int fails = 0;
  logic sel = 1'b0;   // 0: unsigned unit, 1: signed unit
  logic [3:0] vx [MAXN];
  logic [3:0] vw [MAXN];

  wire       cur_rdy = sel ? ifs.in_ready  : ifu.in_ready;
  wire       cur_ov  = sel ? ifs.out_valid : ifu.out_valid;
  wire [7:0] cur_od  = sel ? ifs.out_data  : ifu.out_data;
  wire       cur_os  = sel ? ifs.out_sat   : ifu.out_sat;

  typedef struct packed {
    logic        sel;
    logic [4:0]  n;
    logic [63:0] xs;     // nibble i = x of beat i
    logic [63:0] ws;
    logic [7:0]  bias;
    logic        relu;
    logic [3:0]  hold;
    logic [7:0]  exp_d;
    logic        exp_s;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] xi, input logic [3:0] wi,
                       input logic last, input logic [7:0] b, input logic r);
    ifu.in_valid = v && !sel;
    ifs.in_valid = v && sel;
    ifu.x = xi; ifs.x = xi;
    ifu.w = wi; ifs.w = wi;
    ifu.in_last = last; ifs.in_last = last;
    ifu.bias = b; ifs.bias = b;
    ifu.relu_en = r; ifs.relu_en = r;
  endtask

  task automatic set_ordy(input logic r);
    ifu.out_ready = r;
    ifs.out_ready = r;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle_inputs();
    tick();
    clear = 1'b0;
  endtask

  // Reference: plain integer arithmetic over the vector held in vx/vw.
  function automatic logic [8:0] model(input logic s, input int n, input logic [7:0] b, input logic relu);
    longint acc, amax, amin, omax, omin, xi, wi;
    logic [63:0] bits;
    logic sat;
    amax = s ? 32767 : 65535;
    amin = s ? -32768 : 0;
    omax = s ? 127 : 255;
    omin = s ? -128 : 0;
    acc  = s ? longint'($signed(b)) : longint'(b);
    sat  = 1'b0;
    for (int i = 0; i < n; i++) begin
      xi = s ? longint'($signed(vx[i])) : longint'(vx[i]);
      wi = s ? longint'($signed(vw[i])) : longint'(vw[i]);
      acc = acc + xi * wi;
      if (acc > amax) begin acc = amax; sat = 1'b1; end
      if (acc < amin) begin acc = amin; sat = 1'b1; end
    end
    if (relu && acc < 0) acc = 0;
    if (acc > omax) begin acc = omax; sat = 1'b1; end
    if (acc < omin) begin acc = omin; sat = 1'b1; end
    bits = acc;
    return {sat, bits[7:0]};
  endfunction

  task automatic run_vector(input logic s, input int n, input logic [7:0] b, input logic relu,
                            input int hold, input logic bub, input logic [7:0] ed, input logic es,
                            input string name);
    int f0;
    f0 = fails;
    sel = s;
    set_ordy(hold == 0);
    for (int i = 0; i < n; i++) begin
      if (bub) begin
        repeat ($urandom_range(0, 2)) begin
          idle_inputs();
          tick();
        end
      end
      drive(1'b1, vx[i], vw[i], i == n - 1,
            (i == 0) ? b : 8'($urandom), (i == 0) ? relu : 1'($urandom));
      check({name, " in_ready_beat"}, 32'(cur_rdy), 32'd1);
      tick();
    end
    idle_inputs();
    check({name, " lat_e0"}, 32'(cur_ov), 32'd0);
    tick();
    check({name, " lat_e1"}, 32'(cur_ov), 32'd0);
    check({name, " drain_ready"}, 32'(cur_rdy), 32'd0);
    tick();
    check({name, " lat_e2"}, 32'(cur_ov), 32'd1);
    check({name, " data"}, 32'(cur_od), 32'(ed));
    check({name, " sat"}, 32'(cur_os), 32'(es));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, " hold_valid"}, 32'(cur_ov), 32'd1);
      check({name, " hold_data"}, 32'(cur_od), 32'(ed));
      check({name, " hold_ready"}, 32'(cur_rdy), 32'd0);
    end
    set_ordy(1'b1);
    tick();
    check({name, " valid_drop"}, 32'(cur_ov), 32'd0);
    check({name, " ready_back"}, 32'(cur_rdy), 32'd1);
    $display("[TB] vector %s signed=%0d n=%0d bias=%0h relu=%0d hold=%0d expect data=%0h sat=%0d",
             name, s, n, b, relu, hold, ed, es);
    if (fails != f0) do_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] m;
    logic s, r, bub;
    int n, hold;
    logic [7:0] b;

    rst_n = 1'b1;
    clear = 1'b0;
    sel   = 1'b0;
    idle_inputs();
    set_ordy(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("reset in_ready", 32'(ifu.in_ready), 32'd0);
    check("reset out_valid", 32'(ifu.out_valid), 32'd0);
    check("reset out_data", 32'(ifu.out_data), 32'd0);
    check("reset out_sat", 32'(ifu.out_sat), 32'd0);
    tick();
    check("reset held in_ready", 32'(ifs.in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("ready first edge", 32'(ifu.in_ready), 32'd1);

    // Directed table
    tbl[0] = '{sel:1'b0, n:5'd2,  xs:64'h23, ws:64'h75, bias:8'd1, relu:1'b0, hold:4'd0, exp_d:8'd30, exp_s:1'b0};
    tbl[1] = '{sel:1'b0, n:5'd16, xs:64'hFFFF_FFFF_FFFF_FFFF, ws:64'hFFFF_FFFF_FFFF_FFFF,
               bias:8'd0, relu:1'b0, hold:4'd0, exp_d:8'hFF, exp_s:1'b1};
    tbl[2] = '{sel:1'b1, n:5'd1,  xs:64'hE, ws:64'h3, bias:8'd0, relu:1'b0, hold:4'd0, exp_d:8'hFA, exp_s:1'b0};
    tbl[3] = '{sel:1'b1, n:5'd1,  xs:64'hE, ws:64'h3, bias:8'd0, relu:1'b1, hold:4'd0, exp_d:8'h00, exp_s:1'b0};
    tbl[4] = '{sel:1'b0, n:5'd1,  xs:64'h4, ws:64'h4, bias:8'd2, relu:1'b0, hold:4'd5, exp_d:8'd18, exp_s:1'b0};
    tbl[5] = '{sel:1'b1, n:5'd3,  xs:64'h777, ws:64'h777, bias:8'hF6, relu:1'b0, hold:4'd1, exp_d:8'h7F, exp_s:1'b1};
    tbl[6] = '{sel:1'b0, n:5'd3,  xs:64'h321, ws:64'h654, bias:8'd200, relu:1'b1, hold:4'd2, exp_d:8'hE8, exp_s:1'b0};
    for (int e = 0; e < 7; e++) begin
      for (int i = 0; i < int'(tbl[e].n); i++) begin
        vx[i] = tbl[e].xs[4*i +: 4];
        vw[i] = tbl[e].ws[4*i +: 4];
      end
      run_vector(tbl[e].sel, int'(tbl[e].n), tbl[e].bias, tbl[e].relu, int'(tbl[e].hold),
                 1'b0, tbl[e].exp_d, tbl[e].exp_s, $sformatf("tbl%0d", e));
    end

    // Accumulator saturation: must clamp, never wrap.
    for (int i = 0; i < 520; i++) begin vx[i] = 4'h8; vw[i] = 4'h8; end
    run_vector(1'b1, 520, 8'd0, 1'b0, 0, 1'b0, 8'h7F, 1'b1, "acc_sat_pos");
    for (int i = 0; i < 600; i++) begin vx[i] = 4'h8; vw[i] = 4'h7; end
    run_vector(1'b1, 600, 8'd0, 1'b0, 0, 1'b0, 8'h80, 1'b1, "acc_sat_neg");
    run_vector(1'b1, 600, 8'd0, 1'b1, 0, 1'b0, 8'h00, 1'b1, "acc_sat_neg_relu");

    // Clear mid-vector with a simultaneous last beat
    sel = 1'b0;
    set_ordy(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd5, 4'd5, 1'b0, 8'd0, 1'b0);
      check("clr beat ready", 32'(ifu.in_ready), 32'd1);
      tick();
    end
    clear = 1'b1;
    drive(1'b1, 4'd5, 4'd5, 1'b1, 8'd0, 1'b0);
    tick();
    clear = 1'b0;
    idle_inputs();
    check("clr out_valid", 32'(ifu.out_valid), 32'd0);
    check("clr in_ready", 32'(ifu.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("clr no_output", 32'(ifu.out_valid), 32'd0);
    end
    vx[0] = 4'd1; vw[0] = 4'd1;
    run_vector(1'b0, 1, 8'd0, 1'b0, 0, 1'b0, 8'd1, 1'b0, "after_clear");

    // Clear during HOLD overrides the output transfer
    set_ordy(1'b0);
    drive(1'b1, 4'd9, 4'd9, 1'b1, 8'd0, 1'b0);
    tick();
    idle_inputs();
    tick();
    tick();
    check("hold_clr pre_valid", 32'(ifu.out_valid), 32'd1);
    check("hold_clr pre_data", 32'(ifu.out_data), 32'd81);
    set_ordy(1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("hold_clr out_valid", 32'(ifu.out_valid), 32'd0);
    check("hold_clr out_data", 32'(ifu.out_data), 32'd0);
    check("hold_clr out_sat", 32'(ifu.out_sat), 32'd0);
    check("hold_clr in_ready", 32'(ifu.in_ready), 32'd1);

    // Asynchronous reset mid-vector
    drive(1'b1, 4'd3, 4'd3, 1'b0, 8'd0, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid in_ready", 32'(ifu.in_ready), 32'd0);
    check("rst_mid out_valid", 32'(ifu.out_valid), 32'd0);
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_mid ready_back", 32'(ifu.in_ready), 32'd1);

    // Asynchronous reset during HOLD
    set_ordy(1'b0);
    drive(1'b1, 4'd5, 4'd5, 1'b1, 8'd3, 1'b0);
    tick();
    idle_inputs();
    tick();
    tick();
    check("rst_hold pre_valid", 32'(ifu.out_valid), 32'd1);
    check("rst_hold pre_data", 32'(ifu.out_data), 32'd28);
    #2 rst_n = 1'b0;
    #1;
    check("rst_hold out_valid", 32'(ifu.out_valid), 32'd0);
    check("rst_hold out_data", 32'(ifu.out_data), 32'd0);
    check("rst_hold out_sat", 32'(ifu.out_sat), 32'd0);
    check("rst_hold in_ready", 32'(ifu.in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    vx[0] = 4'd2; vw[0] = 4'd3;
    run_vector(1'b0, 1, 8'd0, 1'b0, 0, 1'b0, 8'd6, 1'b0, "after_reset");

    // Randomized vectors against the reference model
    for (int t = 0; t < 40; t++) begin
      s    = 1'($urandom);
      n    = $urandom_range(1, 8);
      b    = 8'($urandom);
      r    = 1'($urandom);
      hold = $urandom_range(0, 3);
      bub  = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        vx[i] = 4'($urandom);
        vw[i] = 4'($urandom);
      end
      m = model(s, n, b, r);
      run_vector(s, n, b, r, hold, bub, m[7:0], m[8], $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_vector.md
Name: mac_vector

Overview:
- Parametrised streaming multiply-accumulate unit for the perceptron datapath.
- Accepts a vector of (x, w) pairs over a valid/ready handshake and adds a bias.
- Applies optional ReLU, then saturates to OUT_WIDTH.
- Presents one result per vector on a valid/ready output port. Supports signed or unsigned operands, runtime vector length via in_last, and backpressure.

Parameters:
- X_WIDTH, 4, activation operand width
- W_WIDTH, 4, weight operand width
- ACC_WIDTH, 16, internal accumulator width; must be >= X_WIDTH+W_WIDTH+1
- OUT_WIDTH, 8, result width; must be <= ACC_WIDTH
- SIGNED, 0, 0 = unsigned operands/bias/result; 1 = two's-complement

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort: flush pipeline, drop partial vector and pending result
- in_valid  input  1  x/w/in_last/bias/relu_en valid
- in_ready  output  1  unit can accept a beat
- x  input  X_WIDTH  activation
- w  input  W_WIDTH  weight
- in_last  input  1  final beat of current vector
- bias  input  OUT_WIDTH  bias, sampled on first beat of a vector
- relu_en  input  1  ReLU enable, sampled on first beat of a vector
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_WIDTH  saturated result
- out_sat  output  1  result was clipped (accumulator or output saturation)

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_sat=0, in_ready=0. All pipeline valids=0, accumulator=0, state=IDLE. After deassertion, in_ready=1 from the first edge.
- Beat transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- FSM:
  - IDLE: in_ready=1. First beat → ACCUM; capture bias (sign- or zero-extended per SIGNED) and relu_en. If that beat has in_last=1 → DRAIN directly.
  - ACCUM: in_ready=1. Beat with in_last=1 → DRAIN.
  - DRAIN: in_ready=0 while the pipeline empties → HOLD once out_valid sets.
  - HOLD: in_ready=0; out_valid=1. On output transfer, out_valid drops next edge and state → IDLE.
- Pipeline:
  - Stage 1 (edge E, beat accepted): product register p = x*w, full X_WIDTH+W_WIDTH, signed when SIGNED=1.
  - Stage 2 (edge E+1): acc = (first ? bias_ext : acc) + p.
  - The accumulator saturates at ACC_WIDTH limits: unsigned [0, 2^ACC_WIDTH-1]; signed [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. It never wraps; a sticky sat flag is set.
- Output stage (edge E+2 after the last beat at edge E):
  - r = relu_en && acc<0 ? 0 : acc.
  - out_data = r clipped to OUT_WIDTH range (unsigned [0,255] / signed [-128,127] at defaults).
  - out_sat = sticky sat OR clip occurred.
  - out_valid=1.
  - Fixed latency: last beat accepted at edge E → out_valid high after edge E+2.
- Back-to-back beats are accepted every cycle in ACCUM; bubbles (in_valid=0) are allowed anywhere.
- out_data and out_sat hold stable while out_valid && !out_ready.
- Sticky sat clears at the start of each vector.
- clear=1 at an edge:
  - Forces IDLE and clears accumulator, pipeline valids, out_valid, out_sat and out_data to 0.
  - Overrides any simultaneous beat or output transfer; no beat is accepted that cycle.
  - in_ready=1 from the next cycle.
- rst_n asserted mid-vector or mid-HOLD: immediate return to reset values; the partial vector is lost.
- x/w/bias/relu_en are don't-care when not transferring; the unit is insensitive to X on them.

Test Plan:
- Defaults, vector (x=3,w=5),(x=2,w=7,last), bias=1, out_ready=1 → out_data=30, out_sat=0, out_valid exactly 2 edges after last beat, for one cycle.
- Defaults, 16 beats x=15,w=15 back-to-back, bias=0 → out_data=255, out_sat=1; in_ready=1 on every beat cycle.
- SIGNED=1, one beat x=-2,w=3,last, bias=0:
  - relu_en=0 → out_data=0xFA (-6).
  - relu_en=1 → out_data=0, out_sat=0.
- Defaults, single beat x=4,w=4,last, bias=2, out_ready held 0 for 5 cycles → out_data=18 stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1 handshake.
- Defaults, 3 beats accepted, then clear=1 with in_valid=1 → no output, out_valid=0, in_ready=1 next cycle. Next vector (x=1,w=1,last), bias=0 → out_data=1.
- rst_n pulsed low asynchronously mid-vector and during HOLD → out_valid/out_data/out_sat/in_ready all 0 immediately. Next vector (x=2,w=3,last), bias=0 → out_data=6.
